// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and branch-operand
// interlocks, a one-entry mul/div scoreboard, multi-slot flushes and perf counters.
module hazard_ctrl_mc #(
  parameter int REG_W       = 5,
  parameter int MD_LAT      = 8,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_taken,
  input  logic             id_jump,
  input  logic             id_md,
  input  logic [REG_W-1:0] id_dest,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_mem_read,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_dest,
  output logic             pc_ld,
  output logic             if_id_write,
  output logic             nop,
  output logic             flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [REG_W-1:0] md_dest,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int               MDC_W    = $clog2(MD_LAT + 1);
  localparam logic [MDC_W-1:0] MD_LAT_C = MDC_W'(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [MDC_W-1:0] md_cnt_q, md_cnt_d;
  logic [REG_W-1:0] md_dest_q, md_dest_d;
  logic             fl_pend_q, fl_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall, flush_start;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic src_hit(input logic [REG_W-1:0] src, input logic use_src,
                                   input logic [REG_W-1:0] dst);
    return use_src && (src != '0) && (src == dst);
  endfunction

  function automatic logic any_src_hit(input logic [REG_W-1:0] dst);
    return src_hit(id_rs, id_uses_rs, dst) || src_hit(id_rt, id_uses_rt, dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    md_busy = (md_cnt_q != '0);
    md_done = (md_cnt_q == MDC_W'(1));

    stall = (ex_mem_read && any_src_hit(ex_dest))
         || (id_branch && ex_reg_write && any_src_hit(ex_dest))
         || (id_branch && (mem_reg_write || mem_mem_read) && any_src_hit(mem_dest))
         || (md_busy && any_src_hit(md_dest_q))
         || (md_busy && (id_dest == md_dest_q) && (id_dest != '0))
         || (md_busy && id_md);

    // A start while a pending slot is active is absorbed by that slot.
    flush_start = !stall && (id_jump || (id_branch && id_taken)) && !fl_pend_q;
    flush       = flush_start || fl_pend_q;
    fl_pend_d   = (FLUSH_SLOTS == 2) && flush_start;

    pc_ld       = !stall;
    if_id_write = !stall;
    nop         = stall;

    md_cnt_d  = md_cnt_q;
    md_dest_d = md_dest_q;
    if (id_md && !stall) begin
      md_cnt_d  = MD_LAT_C;
      md_dest_d = id_dest;
    end else if (md_busy) begin
      md_cnt_d = md_cnt_q - MDC_W'(1);
    end

    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= '0;
      md_dest_q   <= '0;
      fl_pend_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_dest_q   <= md_dest_d;
      fl_pend_q   <= fl_pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign md_dest   = md_dest_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc (MD_LAT=4, FLUSH_SLOTS=2, CNT_W=4): vector table,
// directed multi-cycle sequences and randomized cycles against a rule-level model.
module tb_hazard_ctrl_mc;

  localparam int P_REG_W = 5;
  localparam int P_MDLAT = 4;
  localparam int P_FS    = 2;
  localparam int P_CNTW  = 4;
  localparam int CMAX    = (1 << P_CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, id_dest, ex_dest, mem_dest;
  logic id_uses_rs, id_uses_rt, id_branch, id_taken, id_jump, id_md;
  logic ex_mem_read, ex_reg_write, mem_mem_read, mem_reg_write;
  logic pc_ld, if_id_write, nop, flush, md_busy, md_done;
  logic [4:0] md_dest;
  logic [3:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_W(P_REG_W), .MD_LAT(P_MDLAT), .FLUSH_SLOTS(P_FS), .CNT_W(P_CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_taken(id_taken), .id_jump(id_jump), .id_md(id_md),
    .id_dest(id_dest), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_dest(ex_dest), .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write),
    .mem_dest(mem_dest), .pc_ld(pc_ld), .if_id_write(if_id_write), .nop(nop),
    .flush(flush), .md_busy(md_busy), .md_done(md_done), .md_dest(md_dest),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic urs, urt, br, tk, jmp, md;
    logic [4:0] dest;
    logic exmr, exrw;
    logic [4:0] exd;
    logic memmr, memrw;
    logic [4:0] memd;
    logic e_pc, e_ifw, e_nop, e_fl;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycle index, first busy cycle of the last issue,
  // cycle holding a pending flush slot, and plain event counts.
  int cyc = 0;
  int m_issue = -100;
  int m_pend = -100;
  int m_sc = 0;
  int m_fc = 0;
  logic [4:0] m_dest = '0;

  logic s_pc, s_ifw, s_nop, s_fl, s_busy, s_done;
  logic [4:0] s_mdd;
  logic [3:0] s_scnt, s_fcnt;

  vec_t vt[14];

  function automatic vec_t mkv(int rs, int rt, int urs, int urt, int br, int tk, int jmp,
                               int md, int dest, int exmr, int exrw, int exd, int memmr,
                               int memrw, int memd, int pc, int ifw, int nopv, int fl);
    vec_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.urs = 1'(urs); v.urt = 1'(urt);
    v.br = 1'(br); v.tk = 1'(tk); v.jmp = 1'(jmp); v.md = 1'(md); v.dest = 5'(dest);
    v.exmr = 1'(exmr); v.exrw = 1'(exrw); v.exd = 5'(exd);
    v.memmr = 1'(memmr); v.memrw = 1'(memrw); v.memd = 5'(memd);
    v.e_pc = 1'(pc); v.e_ifw = 1'(ifw); v.e_nop = 1'(nopv); v.e_fl = 1'(fl);
    return v;
  endfunction

  function automatic vec_t zv();
    return mkv(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_branch = v.br; id_taken = v.tk; id_jump = v.jmp; id_md = v.md; id_dest = v.dest;
    ex_mem_read = v.exmr; ex_reg_write = v.exrw; ex_dest = v.exd;
    mem_mem_read = v.memmr; mem_reg_write = v.memrw; mem_dest = v.memd;
  endtask

  function automatic bit reads(vec_t v, logic [4:0] d);
    return (v.urs && v.rs != 0 && v.rs == d) || (v.urt && v.rt != 0 && v.rt == d);
  endfunction

  function automatic bit stall_m(vec_t v, bit busy, logic [4:0] mdd);
    return (v.exmr && reads(v, v.exd))
        || (v.br && v.exrw && reads(v, v.exd))
        || (v.br && (v.memrw || v.memmr) && reads(v, v.memd))
        || (busy && reads(v, mdd))
        || (busy && v.dest == mdd && v.dest != 0)
        || (busy && v.md);
  endfunction

  function automatic int sat(int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic model_reset();
    m_issue = -100; m_pend = -100; m_sc = 0; m_fc = 0; m_dest = '0;
  endtask

  // Called at a falling edge; checks the cycle against the model, then clocks it.
  task automatic step(input vec_t v);
    bit busy, done, pend, st, fs, fl;
    drive(v);
    #1;
    busy = (cyc >= m_issue) && (cyc < m_issue + P_MDLAT);
    done = (cyc == m_issue + P_MDLAT - 1);
    pend = (cyc == m_pend);
    st   = stall_m(v, busy, m_dest);
    fs   = !st && (v.jmp || (v.br && v.tk)) && !pend;
    fl   = fs || pend;
    s_pc = pc_ld; s_ifw = if_id_write; s_nop = nop; s_fl = flush;
    s_busy = md_busy; s_done = md_done; s_mdd = md_dest;
    s_scnt = stall_cnt; s_fcnt = flush_cnt;
    chk("pc_ld", int'(s_pc), int'(!st));
    chk("if_id_write", int'(s_ifw), int'(!st));
    chk("nop", int'(s_nop), int'(st));
    chk("flush", int'(s_fl), int'(fl));
    chk("md_busy", int'(s_busy), int'(busy));
    chk("md_done", int'(s_done), int'(done));
    chk("md_dest", int'(s_mdd), int'(m_dest));
    chk("stall_cnt", int'(s_scnt), sat(m_sc));
    chk("flush_cnt", int'(s_fcnt), sat(m_fc));
    @(posedge clk);
    if (st) m_sc++;
    if (fl) m_fc++;
    if (v.md && !st) begin
      m_issue = cyc + 1;
      m_dest  = v.dest;
    end
    if (fs && P_FS == 2) m_pend = cyc + 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(zv());
    #1;
    chk("rst pc_ld", int'(pc_ld), 1);
    chk("rst if_id_write", int'(if_id_write), 1);
    chk("rst nop", int'(nop), 0);
    chk("rst flush", int'(flush), 0);
    chk("rst md_busy", int'(md_busy), 0);
    chk("rst md_done", int'(md_done), 0);
    chk("rst md_dest", int'(md_dest), 0);
    chk("rst stall_cnt", int'(stall_cnt), 0);
    chk("rst flush_cnt", int'(flush_cnt), 0);

    //             rs rt urs urt br tk j md dst exmr exrw exd mmr mrw md  pc ifw nop fl
    vt[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    vt[1]  = mkv(8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0,  0, 0, 1, 0);
    vt[2]  = mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0);
    vt[3]  = mkv(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8, 0, 0, 0,  1, 1, 0, 0);
    vt[4]  = mkv(0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0,  0, 0, 1, 0);
    vt[5]  = mkv(0, 9, 0, 1, 1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0,  0, 0, 1, 0);
    vt[6]  = mkv(0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0,  1, 1, 0, 0);
    vt[7]  = mkv(7, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 1, 0);
    vt[8]  = mkv(7, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 7,  0, 0, 1, 0);
    vt[9]  = mkv(7, 3, 1, 1, 1, 1, 0, 0, 0, 0, 1, 4, 0, 1, 6,  1, 1, 0, 1);
    vt[10] = mkv(7, 3, 1, 1, 1, 0, 0, 0, 0, 0, 1, 4, 0, 1, 6,  1, 1, 0, 0);
    vt[11] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 1);
    vt[12] = mkv(2, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0, 0,  0, 0, 1, 0);
    vt[13] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0);

    // Reset held: state stays idle, so each vector sees only combinational rules.
    for (int i = 0; i < 14; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("vec%0d pc_ld", i), int'(pc_ld), int'(vt[i].e_pc));
      chk($sformatf("vec%0d if_id_write", i), int'(if_id_write), int'(vt[i].e_ifw));
      chk($sformatf("vec%0d nop", i), int'(nop), int'(vt[i].e_nop));
      chk($sformatf("vec%0d flush", i), int'(flush), int'(vt[i].e_fl));
    end
    drive(zv());
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Branch after ALU, then operand resolves: two flush slots.
    step(mkv(0,9,0,1,1,1,0,0,0,0,1,9,0,0,0,0,0,0,0));
    chk("br_alu flush", int'(s_fl), 0);
    chk("br_alu nop", int'(s_nop), 1);
    step(mkv(0,9,0,1,1,1,0,0,0,0,1,3,0,0,0,0,0,0,0));
    chk("br_go flush", int'(s_fl), 1);
    chk("br_go pc_ld", int'(s_pc), 1);
    step(zv());
    chk("br_slot2 flush", int'(s_fl), 1);
    step(zv());
    chk("br_after flush", int'(s_fl), 0);

    // Jump: exactly two flush cycles.
    do_reset();
    step(mkv(0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    chk("jmp slot1 flush", int'(s_fl), 1);
    chk("jmp slot1 pc_ld", int'(s_pc), 1);
    step(zv());
    chk("jmp slot2 flush", int'(s_fl), 1);
    chk("jmp slot2 pc_ld", int'(s_pc), 1);
    step(zv());
    chk("jmp end flush", int'(s_fl), 0);
    chk("jmp flush_cnt", int'(s_fcnt), 2);

    // Div to $10, dependent stalls 4 cycles, proceeds on the 5th.
    do_reset();
    step(mkv(0,0,0,0,0,0,0,1,10,0,0,0,0,0,0,0,0,0,0));
    chk("div issue nop", int'(s_nop), 0);
    for (int k = 1; k <= 5; k++) begin
      step(mkv(10,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      chk($sformatf("dep c%0d nop", k), int'(s_nop), (k <= 4) ? 1 : 0);
      chk($sformatf("dep c%0d md_done", k), int'(s_done), (k == 4) ? 1 : 0);
      chk($sformatf("dep c%0d md_busy", k), int'(s_busy), (k <= 4) ? 1 : 0);
    end
    chk("md_dest held", int'(s_mdd), 10);

    // Second div arriving in the md_done cycle stalls once, then issues.
    step(mkv(0,0,0,0,0,0,0,1,12,0,0,0,0,0,0,0,0,0,0));
    for (int k = 0; k < 3; k++) step(zv());
    step(mkv(0,0,0,0,0,0,0,1,13,0,0,0,0,0,0,0,0,0,0));
    chk("div2 in done cycle nop", int'(s_nop), 1);
    chk("div2 done pulse", int'(s_done), 1);
    step(mkv(0,0,0,0,0,0,0,1,13,0,0,0,0,0,0,0,0,0,0));
    chk("div2 issue nop", int'(s_nop), 0);
    step(zv());
    chk("div2 busy", int'(s_busy), 1);
    chk("div2 md_dest", int'(s_mdd), 13);

    // Asynchronous reset with two busy cycles remaining.
    do_reset();
    step(mkv(0,0,0,0,0,0,0,1,10,0,0,0,0,0,0,0,0,0,0));
    step(zv());
    step(zv());
    rst_n = 1'b0;
    #1;
    chk("async rst md_busy", int'(md_busy), 0);
    chk("async rst md_done", int'(md_done), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(zv());
      chk($sformatf("post rst done c%0d", k), int'(s_done), 0);
    end
    chk("post rst stall_cnt", int'(s_scnt), 0);
    chk("post rst flush_cnt", int'(s_fcnt), 0);

    // Stall held 20 cycles saturates the 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) step(mkv(8,0,1,0,0,0,0,0,0,1,0,8,0,0,0,0,0,0,0));
    step(zv());
    chk("stall_cnt saturated", int'(s_scnt), 15);

    // Randomized cycles over a small register set to provoke hazards.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      v = zv();
      v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
      v.urs = 1'($urandom_range(0, 1)); v.urt = 1'($urandom_range(0, 1));
      v.br = ($urandom_range(0, 3) == 0); v.tk = 1'($urandom_range(0, 1));
      v.jmp = ($urandom_range(0, 7) == 0); v.md = ($urandom_range(0, 5) == 0);
      v.dest = 5'($urandom_range(0, 3));
      v.exmr = ($urandom_range(0, 3) == 0); v.exrw = 1'($urandom_range(0, 1));
      v.exd = 5'($urandom_range(0, 3));
      v.memmr = ($urandom_range(0, 3) == 0); v.memrw = 1'($urandom_range(0, 1));
      v.memd = 5'($urandom_range(0, 3));
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
